// File: rtl/const_stream_checker_pkg.sv
// Shared definitions for the generated-FSM word stream: state encoding,
// datapath widths and the word comparison used by stream consumers.
package const_stream_checker_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned CNT_W  = 16;

   typedef enum logic [7:0] {
      ST_INIT  = 8'd0,
      ST_WAIT  = 8'd1,
      ST_CHECK = 8'd2,
      ST_PASS  = 8'd3,
      ST_FAIL  = 8'd4
   } state_e;

   function automatic logic word_match(input logic [WORD_W-1:0] a,
                                       input logic [WORD_W-1:0] b);
      return (a == b);
   endfunction

endpackage

// File: rtl/stream_timeout_ctr.sv
// Loadable down-counter bounding the time spent waiting for the first valid word.
// expired_o flags that the next enabled decrement is the final permitted cycle.
module stream_timeout_ctr #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             en_i,
   output logic             expired_o
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // Next count: load wins over decrement, and the count saturates at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == ONE);

endmodule

// File: rtl/const_stream_checker.sv
// Consumer-side checker: the stream must settle to EXPECTED within TIMEOUT cycles
// and then hold for MIN_COUNT valid words; the verdict is sticky until reset.
module const_stream_checker
   import const_stream_checker_pkg::*;
#(
   parameter logic [WORD_W-1:0] EXPECTED  = 32'd1,
   parameter logic [CNT_W-1:0]  MIN_COUNT = 16'd4,
   parameter logic [CNT_W-1:0]  TIMEOUT   = 16'd255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WORD_W-1:0] in1,
   input  logic              in2,
   output logic              pass,
   output logic              fail,
   output logic              done,
   output logic              timed_out,
   output logic [CNT_W-1:0]  word_count,
   output logic [WORD_W-1:0] last_bad
);

   state_e             state_q, state_d;
   logic               pass_q, pass_d;
   logic               fail_q, fail_d;
   logic               done_q, done_d;
   logic               timed_out_q, timed_out_d;
   logic [CNT_W-1:0]   word_count_q, word_count_d;
   logic [WORD_W-1:0]  last_bad_q, last_bad_d;
   logic [CNT_W-1:0]   wc_inc_s;
   logic               ctr_load_s;
   logic               ctr_en_s;
   logic               ctr_expired_s;

   stream_timeout_ctr #(
      .WIDTH(CNT_W)
   ) u_timeout_ctr (
      .clk_i      (clk),
      .rst_n_i    (reset),
      .load_i     (ctr_load_s),
      .load_val_i (TIMEOUT),
      .en_i       (ctr_en_s),
      .expired_o  (ctr_expired_s)
   );

   assign wc_inc_s = word_count_q + 16'd1;

   // Next-state and verdict logic; terminal states simply hold everything.
   always_comb begin
      state_d      = state_q;
      pass_d       = pass_q;
      fail_d       = fail_q;
      timed_out_d  = timed_out_q;
      word_count_d = word_count_q;
      last_bad_d   = last_bad_q;
      ctr_load_s   = 1'b0;
      ctr_en_s     = 1'b0;
      case (state_q)
         ST_INIT: begin
            word_count_d = 16'd0;
            last_bad_d   = 32'd0;
            pass_d       = 1'b0;
            fail_d       = 1'b0;
            timed_out_d  = 1'b0;
            ctr_load_s   = 1'b1;
            state_d      = ST_WAIT;
         end
         ST_WAIT: begin
            // A valid word outranks a timeout landing on the same cycle.
            if (in2) begin
               if (word_match(in1, EXPECTED)) begin
                  word_count_d = 16'd1;
                  if (MIN_COUNT == 16'd1) begin
                     pass_d  = 1'b1;
                     state_d = ST_PASS;
                  end else begin
                     state_d = ST_CHECK;
                  end
               end else begin
                  last_bad_d = in1;
                  fail_d     = 1'b1;
                  state_d    = ST_FAIL;
               end
            end else begin
               ctr_en_s = 1'b1;
               if (ctr_expired_s) begin
                  fail_d      = 1'b1;
                  timed_out_d = 1'b1;
                  state_d     = ST_FAIL;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_CHECK: begin
            if (!in2) begin
               fail_d  = 1'b1;
               state_d = ST_FAIL;
            end else if (word_match(in1, EXPECTED)) begin
               word_count_d = wc_inc_s;
               if (wc_inc_s == MIN_COUNT) begin
                  pass_d  = 1'b1;
                  state_d = ST_PASS;
               end else begin
                  state_d = ST_CHECK;
               end
            end else begin
               last_bad_d = in1;
               fail_d     = 1'b1;
               state_d    = ST_FAIL;
            end
         end
         ST_PASS: begin
            state_d = ST_PASS;
         end
         ST_FAIL: begin
            state_d = ST_FAIL;
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
      done_d = pass_d | fail_d;
   end

   // State and output registers; reset overrides any pending transition.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= ST_INIT;
         pass_q       <= 1'b0;
         fail_q       <= 1'b0;
         done_q       <= 1'b0;
         timed_out_q  <= 1'b0;
         word_count_q <= 16'd0;
         last_bad_q   <= 32'd0;
      end else begin
         state_q      <= state_d;
         pass_q       <= pass_d;
         fail_q       <= fail_d;
         done_q       <= done_d;
         timed_out_q  <= timed_out_d;
         word_count_q <= word_count_d;
         last_bad_q   <= last_bad_d;
      end
   end

   assign pass       = pass_q;
   assign fail       = fail_q;
   assign done       = done_q;
   assign timed_out  = timed_out_q;
   assign word_count = word_count_q;
   assign last_bad   = last_bad_q;

endmodule
